apb_cmd_master: RTL and testbench

Parametrised APB4 master: accepts read/write commands on a valid/ready stream, buffers them in a small FIFO, and executes them one at a time on the APB bus. Each transfer returns a response with read data and error status. Supports slave wait states, PSLVERR, byte strobes and a wait-state timeout. It replaces task-driven APB stimulus and is the bus master for the register blocks on the radio control path.

---
 rtl/apb_pkg.sv | 35 +++
 rtl/apb_cmd_fifo.sv | 63 ++++++
 rtl/apb_cmd_master.sv | 159 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master: FSM state encoding,
// response codes and the command record carried through the command FIFO.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_SLVERR  = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT = 2'b10;

   // Record field widths; these are the upper bounds for the master's
   // ADDR_W/DATA_W parameters (narrower buses zero-extend into the record).
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 32;
   localparam int CMD_STRB_W = CMD_DATA_W / 8;

   typedef struct packed {
      logic                  write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
      logic [CMD_STRB_W-1:0] strb;
   } apb_cmd_t;

   localparam int CMD_W = $bits(apb_cmd_t);

   // Response code for a transfer the slave completed with pready.
   function automatic logic [1:0] done_code(input logic slverr);
      return slverr ? RSP_SLVERR : RSP_OK;
   endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for queued APB commands.
// DEPTH must be a power of two so the pointers wrap naturally.
module apb_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 master: queues read/write commands from a valid/ready stream and runs
// them one at a time on the bus, returning one response per transfer.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | bus quiet; pops next command once the response slot is free
//   SETUP  | psel=1, penable=0; address/data/strobe driven
//   ACCESS | psel=1, penable=1; waits for pready or the wait-state limit
module apb_cmd_master #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CMD_DEPTH = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [1:0]            rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_W-1:0]     paddr,
   output logic [DATA_W-1:0]     pwdata,
   output logic [DATA_W/8-1:0]   pstrb,
   input  logic [DATA_W-1:0]     prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   output logic                  busy
);

   import apb_pkg::*;

   localparam int STRB_W = DATA_W / 8;
   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   apb_cmd_t                    push_cmd;
   apb_cmd_t                    pop_cmd;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(CMD_DEPTH):0]  fifo_count;
   logic                        start;
   logic                        wait_expired;
   apb_state_t                  state;
   logic [WAIT_W-1:0]           wait_cnt;

   // Pack the incoming command into the FIFO record.
   always_comb begin
      push_cmd       = '0;
      push_cmd.write = cmd_write;
      push_cmd.addr  = CMD_ADDR_W'(cmd_addr);
      push_cmd.wdata = CMD_DATA_W'(cmd_wdata);
      push_cmd.strb  = CMD_STRB_W'(cmd_strb);
   end

   apb_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .pop   (start),
      .din   (push_cmd),
      .dout  (pop_cmd),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign cmd_ready = !fifo_full;

   // A new transfer may start only when the response slot is free or is
   // being drained this same cycle, so a completion never overwrites one.
   assign start = (state == IDLE) && !fifo_empty && (!rsp_valid || rsp_ready);

   // The wait counter holds the number of wait states already seen; the
   // current ACCESS cycle without pready is the last one allowed.
   assign wait_expired = (TIMEOUT != 0) && !pready && (wait_cnt == WAIT_LAST);

   assign busy = (state != IDLE) || (fifo_count != '0) || rsp_valid;

   // Transfer sequencer with registered APB outputs and response register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pstrb     <= '0;
         wait_cnt  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= RSP_OK;
      end else begin
         if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SETUP;
                  psel     <= 1'b1;
                  penable  <= 1'b0;
                  pwrite   <= pop_cmd.write;
                  paddr    <= pop_cmd.addr[ADDR_W-1:0];
                  pwdata   <= pop_cmd.write ? pop_cmd.wdata[DATA_W-1:0] : '0;
                  pstrb    <= pop_cmd.write ? pop_cmd.strb[STRB_W-1:0]  : '0;
                  wait_cnt <= '0;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               penable <= 1'b1;
            end
            ACCESS: begin
               if (pready) begin
                  state     <= IDLE;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  pwdata    <= '0;
                  pstrb     <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= done_code(pslverr);
                  rsp_rdata <= pwrite ? '0 : prdata;
               end else if (wait_expired) begin
                  state     <= IDLE;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  pwdata    <= '0;
                  pstrb     <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= RSP_TIMEOUT;
                  rsp_rdata <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_ONE;
               end
            end
            default: begin
               state   <= IDLE;
               psel    <= 1'b0;
               penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small configurable APB slave.
module tb_apb_cmd_master;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        busy;

   // slave model controls
   int          slv_waits;
   logic        slv_hang;
   logic        slv_err;
   logic        slv_echo;
   logic [31:0] slv_rdata;
   int          acc_cnt;

   int          n_tests;
   int          n_fail;

   apb_cmd_master #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .CMD_DEPTH (4),
      .TIMEOUT   (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_strb  (cmd_strb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: pready after slv_waits wait states in ACCESS unless hung.
   assign pready  = !slv_hang && psel && penable && (acc_cnt == slv_waits);
   assign pslverr = slv_err && pready;
   assign prdata  = slv_echo ? paddr : slv_rdata;

   // Count ACCESS cycles already spent waiting.
   always @(posedge clk) begin
      acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      int n;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      check("push cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int bound);
      int n;
      n = 0;
      while (!rsp_valid && n < bound) begin
         tick();
         n++;
      end
      check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
   endtask

   initial begin
      int cnt;
      int acc;
      logic ok;

      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b1;
      slv_waits = 0;
      slv_hang  = 1'b0;
      slv_err   = 1'b0;
      slv_echo  = 1'b0;
      slv_rdata = '0;

      // reset state
      #2;
      check("rst psel",      {31'd0, psel},      32'd0);
      check("rst penable",   {31'd0, penable},   32'd0);
      check("rst pwrite",    {31'd0, pwrite},    32'd0);
      check("rst paddr",     paddr,              32'd0);
      check("rst pwdata",    pwdata,             32'd0);
      check("rst pstrb",     {28'd0, pstrb},     32'd0);
      check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst rsp_rdata", rsp_rdata,          32'd0);
      check("rst rsp_err",   {30'd0, rsp_err},   32'd0);
      check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst busy",      {31'd0, busy},      32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // zero-wait write
      push(1'b1, 32'h0123_4560, 32'hAABB_CCDD, 4'hF);
      check("wr E0 psel", {31'd0, psel}, 32'd0);
      tick();
      check("wr E1 psel",    {31'd0, psel},    32'd1);
      check("wr E1 penable", {31'd0, penable}, 32'd0);
      check("wr E1 pwrite",  {31'd0, pwrite},  32'd1);
      check("wr E1 paddr",   paddr,            32'h0123_4560);
      check("wr E1 pwdata",  pwdata,           32'hAABB_CCDD);
      check("wr E1 pstrb",   {28'd0, pstrb},   32'hF);
      tick();
      check("wr E2 psel",    {31'd0, psel},    32'd1);
      check("wr E2 penable", {31'd0, penable}, 32'd1);
      check("wr E2 pwdata",  pwdata,           32'hAABB_CCDD);
      check("wr E2 rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("wr E3 psel",      {31'd0, psel},      32'd0);
      check("wr E3 penable",   {31'd0, penable},   32'd0);
      check("wr E3 rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("wr E3 rsp_err",   {30'd0, rsp_err},   32'd0);
      check("wr E3 rsp_rdata", rsp_rdata,          32'd0);
      check("wr E3 pwdata idle", pwdata,           32'd0);
      check("wr E3 pstrb idle",  {28'd0, pstrb},   32'd0);
      check("wr E3 paddr hold",  paddr,            32'h0123_4560);
      tick();
      check("wr drained rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("wr drained busy",      {31'd0, busy},      32'd0);

      // read with 3 wait states
      slv_waits = 3;
      slv_rdata = 32'h0000_0001;
      push(1'b0, 32'h0123_4570, 32'h5555_5555, 4'hF);
      tick();
      check("rd SETUP psel",   {31'd0, psel},   32'd1);
      check("rd SETUP pwrite", {31'd0, pwrite}, 32'd0);
      check("rd SETUP paddr",  paddr,           32'h0123_4570);
      check("rd SETUP pstrb",  {28'd0, pstrb},  32'd0);
      check("rd SETUP pwdata", pwdata,          32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rd ACCESS penable",   {31'd0, penable},   32'd1);
         check("rd ACCESS rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
      tick();
      check("rd done penable",   {31'd0, penable},   32'd0);
      check("rd done rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rd done rsp_rdata", rsp_rdata,          32'h0000_0001);
      check("rd done rsp_err",   {30'd0, rsp_err},   32'd0);
      tick();

      // read with slave error
      slv_waits = 0;
      slv_err   = 1'b1;
      slv_rdata = 32'hDEAD_BEEF;
      push(1'b0, 32'h0000_0080, 32'h0, 4'h0);
      wait_rsp("slverr", 10);
      check("slverr rsp_err",   {30'd0, rsp_err}, 32'd1);
      check("slverr rsp_rdata", rsp_rdata,        32'hDEAD_BEEF);
      slv_err = 1'b0;
      tick();

      // timeout then a queued write
      slv_hang  = 1'b1;
      slv_rdata = 32'h1234_5678;
      push(1'b0, 32'h0000_0A00, 32'h0, 4'h0);
      push(1'b1, 32'h0000_0B00, 32'hCAFE_F00D, 4'h3);
      cnt = 0;
      for (int n = 0; n < 40 && !rsp_valid; n++) begin
         tick();
         if (penable) cnt++;
      end
      slv_hang = 1'b0;
      check("tmo access cycles", 32'(cnt),          32'd16);
      check("tmo rsp_valid",     {31'd0, rsp_valid}, 32'd1);
      check("tmo rsp_err",       {30'd0, rsp_err},   32'd2);
      check("tmo rsp_rdata",     rsp_rdata,          32'd0);
      tick();
      check("tmo next psel",   {31'd0, psel}, 32'd1);
      check("tmo next pstrb",  {28'd0, pstrb}, 32'h3);
      check("tmo next pwdata", pwdata,        32'hCAFE_F00D);
      wait_rsp("after tmo", 10);
      check("after tmo rsp_err",   {30'd0, rsp_err}, 32'd0);
      check("after tmo rsp_rdata", rsp_rdata,        32'd0);
      check("after tmo paddr",     paddr,            32'h0000_0B00);
      tick();

      // backpressure: fill FIFO while a response is held
      rsp_ready = 1'b0;
      slv_echo  = 1'b1;
      cmd_write = 1'b0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      cmd_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_addr = 32'(32'h100 + acc * 4);
         ok = cmd_ready;
         tick();
         if (ok) acc++;
      end
      check("bp accepted",  32'(acc),            32'd5);
      check("bp cmd_ready", {31'd0, cmd_ready},  32'd0);
      for (int i = 0; i < 3; i++) tick();
      check("bp held cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp held rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp held psel",      {31'd0, psel},      32'd0);
      check("bp held busy",      {31'd0, busy},      32'd1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_rsp("bp rsp", 10);
         check("bp rsp order", rsp_rdata, 32'(32'h100 + k * 4));
         if (k == 4) check("bp busy before last", {31'd0, busy}, 32'd1);
         tick();
         if (k == 0) check("bp cmd_ready after pop", {31'd0, cmd_ready}, 32'd1);
      end
      check("bp busy after last", {31'd0, busy}, 32'd0);
      slv_echo = 1'b0;

      // reset with a held response and a queued command
      rsp_ready = 1'b0;
      slv_waits = 0;
      push(1'b0, 32'h0000_0200, 32'h0, 4'h0);
      push(1'b0, 32'h0000_0204, 32'h0, 4'h0);
      wait_rsp("rst1", 10);
      check("rst1 busy before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("rst1 rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst1 busy",      {31'd0, busy},      32'd0);
      check("rst1 cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      reset     = 1'b1;
      rsp_ready = 1'b1;
      tick();

      // reset during ACCESS
      slv_waits = 5;
      push(1'b0, 32'h0000_0300, 32'h0, 4'h0);
      push(1'b1, 32'h0000_0304, 32'h1, 4'h1);
      tick();
      check("rst2 in ACCESS", {31'd0, penable}, 32'd1);
      reset = 1'b0;
      #1;
      check("rst2 psel",      {31'd0, psel},      32'd0);
      check("rst2 penable",   {31'd0, penable},   32'd0);
      check("rst2 busy",      {31'd0, busy},      32'd0);
      check("rst2 rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      reset = 1'b1;
      check("rst2 cmd_ready", {31'd0, cmd_ready}, 32'd1);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (psel) cnt++;
      end
      check("rst2 no stale transfer", 32'(cnt), 32'd0);
      check("rst2 no stale rsp", {31'd0, rsp_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
